alu_wb_stage: RTL
=================

Name: alu_wb_stage

Overview:
- Writeback stage directly downstream of the 8-bit combinational `alu`.
- Captures `result` and `flags` from the ALU through a valid/ready handshake and buffers them in a 2-entry FIFO.
- Retires entries to the register-file write port, which may stall.
- Owns the architectural status (flags) register, updated per operation class, so downstream stalls never lose an ALU result.

Parameters:
- DEPTH, 2, buffer entries; must be a power of two ≥ 2.
- ARITH_FLAG_MASK, 8'hFF, flag bits updated on retirement of a mode=1 (arithmetic) op.
- LOGIC_FLAG_MASK, 8'h0F, flag bits updated on retirement of a mode=0 (logical) op.

Ports:
- clk  input  1  single clock for the whole block.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU output is valid this cycle.
- in_ready  output  1  stage can accept this cycle.
- in_mode  input  1  ALU mode of the op (1 = arithmetic, 0 = logical).
- in_op  input  4  ALU operation code.
- in_result  input  8  ALU result.
- in_flags  input  8  ALU flags.
- in_dest  input  3  destination register index.
- in_wb_en  input  1  op writes a register (0 = flags-only, e.g. compare).
- rf_we  output  1  register-file write strobe.
- rf_waddr  output  3  write address.
- rf_wdata  output  8  write data.
- rf_ready  input  1  register file accepts the write this cycle.
- flag_wr_en  input  1  explicit flag-register write (CPU flag instructions).
- flag_wr_data  input  8  explicit flag value.
- status  output  8  architectural flag register.
- busy  output  1  buffer is non-empty.

Behaviour:
- Reset (async, rst_n=0): buffer empty, count=0, rd/wr pointers=0, status=8'h00, rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, in_ready=1 once released.
- Accept: on a rising edge with in_valid & in_ready, store {mode, op, result, flags, dest, wb_en} at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
- Back-pressure: in_ready = (count != DEPTH), driven from registered count only. No combinational path from rf_ready to in_ready.
- Head presentation: whenever count > 0, the head entry drives rf_waddr and rf_wdata. rf_we = head.wb_en & (count > 0).
- Retirement: head retires on an edge where count > 0 and (rf_ready or head.wb_en = 0). Flags-only entries retire without waiting for rf_ready. rd_ptr increments and wraps.
- Latency: accept at edge N → rf_we high during cycle N+1 if the buffer was empty. Sustained throughput is 1 op/cycle with rf_ready held high.
- Simultaneous accept and retire: count is unchanged and both pointers advance. With count = DEPTH, in_ready is 0, so only the retire occurs.
- Flag update on retirement: status <= (status & ~M) | (head.flags & M). M = ARITH_FLAG_MASK if head.mode = 1, else LOGIC_FLAG_MASK.
- Opcode 4'd0 in either mode is a NOP: it retires with rf_we=0 and no flag change, regardless of wb_en.
- Explicit flag write: flag_wr_en on an edge sets status <= flag_wr_data. It takes priority over a retirement flag update on the same edge; that retirement still completes its register write.
- Outputs when empty: rf_waddr and rf_wdata hold their last values, rf_we=0.
- Reset mid-operation: all buffered entries are discarded immediately; no partial write is issued after reset release.
- Pointers are log2(DEPTH) bits and count is log2(DEPTH)+1 bits. There is no overflow or underflow path; an accept while full is impossible by construction, and the bench asserts this.

Decomposition:
- Shared package `alu_pkg`:
  - MODE_LOGIC / MODE_ARITH constants.
  - Opcode localparams: OP_NOP=0, OP_ADD=1 … OP_DEC=10 (arith); OP_AND=1 … OP_ZERO=12 (logic).
  - Flag bit index constants.
  - Packed `wb_entry_t` typedef.
- One sub-module, `wb_fifo` (generic DEPTH × width storage plus pointer/count logic). Flag masking and retirement control stay in the top level.

Test Plan:
- Single op: mode=1, op=1, result=8'h08, flags=8'h00, dest=3, wb_en=1, rf_ready=1 → next cycle rf_we=1, rf_waddr=3, rf_wdata=8'h08; busy drops the cycle after.
- Stall/fill: rf_ready=0, push 8'h08 then 8'h0C → in_ready=0 after the 2nd push, 3rd in_valid held off. Raise rf_ready → writes 8'h08 then 8'h0C in order, in_ready re-asserts after the first retire.
- Flag masking: status=8'hFF, retire mode=0, flags=8'h00 → status=8'hF0. Then retire mode=1, flags=8'hA5 → status=8'hA5.
- Priority: on the same edge, retire mode=1 flags=8'h01 and flag_wr_en=1 data=8'h80 → status=8'h80, and the register write still occurs.
- NOP and flags-only: op=0 with wb_en=1 → no rf_we, status unchanged. wb_en=0, mode=1, flags=8'h02, rf_ready=0 → retires anyway, status updated, rf_we=0.
- Reset mid-stall: 2 entries buffered, rf_ready=0, pulse rst_n low asynchronously → busy=0, rf_we=0, status=8'h00 immediately; no writes after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: mode/opcode encodings, flag bit positions and the
// writeback buffer entry layout.
package alu_pkg;

   localparam logic MODE_LOGIC = 1'b0;
   localparam logic MODE_ARITH = 1'b1;

   // Arithmetic opcodes (mode = 1)
   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_ADC  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_SBC  = 4'd4;
   localparam logic [3:0] OP_CMP  = 4'd5;
   localparam logic [3:0] OP_NEG  = 4'd6;
   localparam logic [3:0] OP_ASL  = 4'd7;
   localparam logic [3:0] OP_ASR  = 4'd8;
   localparam logic [3:0] OP_INC  = 4'd9;
   localparam logic [3:0] OP_DEC  = 4'd10;

   // Logical opcodes (mode = 0)
   localparam logic [3:0] OP_AND  = 4'd1;
   localparam logic [3:0] OP_OR   = 4'd2;
   localparam logic [3:0] OP_XOR  = 4'd3;
   localparam logic [3:0] OP_NOT  = 4'd4;
   localparam logic [3:0] OP_NAND = 4'd5;
   localparam logic [3:0] OP_NOR  = 4'd6;
   localparam logic [3:0] OP_XNOR = 4'd7;
   localparam logic [3:0] OP_SHL  = 4'd8;
   localparam logic [3:0] OP_SHR  = 4'd9;
   localparam logic [3:0] OP_ROL  = 4'd10;
   localparam logic [3:0] OP_ROR  = 4'd11;
   localparam logic [3:0] OP_ZERO = 4'd12;

   // Flag bit positions within the 8-bit flag/status word
   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_P = 3;
   localparam int FLAG_V = 4;
   localparam int FLAG_H = 5;
   localparam int FLAG_S = 6;
   localparam int FLAG_X = 7;

   typedef struct packed {
      logic       mode;
      logic [3:0] op;
      logic [7:0] result;
      logic [7:0] flags;
      logic [2:0] dest;
      logic       wb_en;
   } wb_entry_t;

   localparam int WB_ENTRY_W = $bits(wb_entry_t);

   function automatic logic is_nop(input logic [3:0] op);
      return op == OP_NOP;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Generic DEPTH x WIDTH FIFO with registered pointers/count; head is read
// combinationally from the storage array.
module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem[rd_ptr_reg];

   // Storage carries no reset: validity is tracked solely by count_reg.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: buffers ALU results, retires them to the register file
// write port and maintains the architectural status (flag) register.
module alu_wb_stage
   import alu_pkg::*;
#(
   parameter int         DEPTH           = 2,
   parameter logic [7:0] ARITH_FLAG_MASK = 8'hFF,
   parameter logic [7:0] LOGIC_FLAG_MASK = 8'h0F
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_mode,
   input  logic [3:0] in_op,
   input  logic [7:0] in_result,
   input  logic [7:0] in_flags,
   input  logic [2:0] in_dest,
   input  logic       in_wb_en,
   output logic       rf_we,
   output logic [2:0] rf_waddr,
   output logic [7:0] rf_wdata,
   input  logic       rf_ready,
   input  logic       flag_wr_en,
   input  logic [7:0] flag_wr_data,
   output logic [7:0] status,
   output logic       busy
);

   wb_entry_t  in_entry;
   wb_entry_t  head;
   logic       fifo_full;
   logic       fifo_empty;
   logic       push;
   logic       retire;
   logic       has_head;
   logic       head_writes;
   logic [7:0] flag_mask;
   logic [7:0] status_reg;
   logic [7:0] status_next;
   logic [2:0] last_waddr_reg;
   logic [7:0] last_wdata_reg;

   always_comb begin
      in_entry        = '0;
      in_entry.mode   = in_mode;
      in_entry.op     = in_op;
      in_entry.result = in_result;
      in_entry.flags  = in_flags;
      in_entry.dest   = in_dest;
      in_entry.wb_en  = in_wb_en;
   end

   // in_ready depends only on the registered fill level, never on rf_ready.
   assign in_ready = ~fifo_full;
   assign push     = in_valid & in_ready;

   wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WB_ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (retire),
      .wr_data (in_entry),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // A NOP never writes, so it (like a flags-only op) need not wait for rf_ready.
   assign has_head    = ~fifo_empty;
   assign head_writes = head.wb_en & ~is_nop(head.op);
   assign retire      = has_head & (rf_ready | ~head_writes);
   assign flag_mask   = (head.mode == MODE_ARITH) ? ARITH_FLAG_MASK : LOGIC_FLAG_MASK;

   always_comb begin
      status_next = status_reg;
      if (flag_wr_en) begin
         status_next = flag_wr_data;
      end else if (retire && !is_nop(head.op)) begin
         status_next = (status_reg & ~flag_mask) | (head.flags & flag_mask);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_reg     <= 8'h00;
         last_waddr_reg <= '0;
         last_wdata_reg <= '0;
      end else begin
         status_reg <= status_next;
         if (has_head) begin
            last_waddr_reg <= head.dest;
            last_wdata_reg <= head.result;
         end
      end
   end

   assign rf_we    = has_head & head_writes;
   assign rf_waddr = has_head ? head.dest   : last_waddr_reg;
   assign rf_wdata = has_head ? head.result : last_wdata_reg;
   assign status   = status_reg;
   assign busy     = has_head;

endmodule
